// File: rtl/priv_key_gen_pkg.sv
// +----------------------------------------------------------------------------+
// | priv_key_gen_pkg                                                           |
// | State encoding and width rules for the RSA key-generation stages.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package priv_key_gen_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    DIV_START = 3'd2,
    DIV_WAIT  = 3'd3,
    UPDATE    = 3'd4,
    FIX       = 3'd5,
    FAIL      = 3'd6,
    DONE      = 3'd7
  } state_e;

  // Bezout coefficients need two bits beyond 2*WIDTH for sign and headroom.
  function automatic int t_width(input int width);
    return 2 * width + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsa_div.sv
// +----------------------------------------------------------------------------+
// | rsa_div                                                                    |
// | Unsigned restoring divider, one quotient bit per cycle, WIDTH cycles.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rsa_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic             done_q;

  logic [WIDTH-1:0] w_src_rem;
  logic [WIDTH-1:0] w_src_quo;
  logic [WIDTH-1:0] w_dsr;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // The load cycle already performs the first step so the result lands in WIDTH cycles.
  assign w_src_rem = div_start ? '0 : rem_q;
  assign w_src_quo = div_start ? dividend : quo_q;
  assign w_dsr     = div_start ? divisor : dsr_q;
  assign w_trial   = {w_src_rem, w_src_quo[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, w_dsr});
  assign w_rem_nxt = w_ge ? (w_trial[WIDTH-1:0] - w_dsr) : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {w_src_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (div_start) begin
        quo_q  <= w_quo_nxt;
        rem_q  <= w_rem_nxt;
        dsr_q  <= divisor;
        cnt_q  <= CNT_W'(1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quo_q <= w_quo_nxt;
        rem_q <= w_rem_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_done  = done_q;

endmodule

`default_nettype wire

// File: rtl/priv_key_gen.sv
// +----------------------------------------------------------------------------+
// | priv_key_gen                                                               |
// | Computes d = e^-1 mod phi with the iterative extended Euclidean algorithm. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module priv_key_gen
  import priv_key_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   e,
  input  logic [2*WIDTH-1:0] phi,
  output logic [2*WIDTH-1:0] d,
  output logic               fail,
  output logic               finish
);

  localparam int PW  = 2 * WIDTH;
  localparam int T_W = t_width(WIDTH);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      e_q, e_d;
  logic [PW-1:0]         phi_q, phi_d;
  logic [PW-1:0]         r0_q, r0_d;
  logic [PW-1:0]         r1_q, r1_d;
  logic signed [T_W-1:0] t0_q, t0_d;
  logic signed [T_W-1:0] t1_q, t1_d;
  logic [PW-1:0]         qt_q, qt_d;
  logic [PW-1:0]         rm_q, rm_d;
  logic [PW-1:0]         d_q, d_d;
  logic                  fail_q, fail_d;

  logic                  w_div_start;
  logic                  w_div_done;
  logic [PW-1:0]         w_quot;
  logic [PW-1:0]         w_rem;
  logic signed [T_W-1:0] w_qt_s;
  logic signed [T_W-1:0] w_prod;

  rsa_div #(
    .WIDTH (PW)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_start (w_div_start),
    .dividend  (r0_q),
    .divisor   (r1_q),
    .quotient  (w_quot),
    .remainder (w_rem),
    .div_done  (w_div_done)
  );

  // |t| never exceeds phi, so the T_W-bit truncated product is exact.
  assign w_qt_s = {2'b00, qt_q};
  assign w_prod = w_qt_s * t1_q;

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    phi_d       = phi_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    qt_d        = qt_q;
    rm_d        = rm_q;
    d_d         = d_q;
    fail_d      = fail_q;
    w_div_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          e_d     = e;
          phi_d   = phi;
          state_d = LOAD;
        end
      end
      LOAD: begin
        r0_d = phi_q;
        r1_d = {{WIDTH{1'b0}}, e_q};
        t0_d = '0;
        t1_d = T_W'(1);
        if ((e_q == '0) || (phi_q < PW'(2)) || ({{WIDTH{1'b0}}, e_q} >= phi_q)) begin
          state_d = FAIL;
        end else begin
          state_d = DIV_START;
        end
      end
      DIV_START: begin
        w_div_start = 1'b1;
        state_d     = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (w_div_done) begin
          qt_d    = w_quot;
          rm_d    = w_rem;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        r0_d    = r1_q;
        r1_d    = rm_q;
        t0_d    = t1_q;
        t1_d    = t0_q - w_prod;
        state_d = (rm_q != '0) ? DIV_START : FIX;
      end
      FIX: begin
        if (r0_q != PW'(1)) begin
          fail_d = 1'b1;
          d_d    = '0;
        end else begin
          // Modular add at PW bits yields the same low bits as the wide add.
          fail_d = 1'b0;
          d_d    = t0_q[T_W-1] ? (t0_q[PW-1:0] + phi_q) : t0_q[PW-1:0];
        end
        state_d = DONE;
      end
      FAIL: begin
        fail_d  = 1'b1;
        d_d     = '0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_q     <= '0;
      phi_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      qt_q    <= '0;
      rm_q    <= '0;
      d_q     <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      phi_q   <= phi_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      qt_q    <= qt_d;
      rm_q    <= rm_d;
      d_q     <= d_d;
      fail_q  <= fail_d;
    end
  end

  assign d      = d_q;
  assign fail   = fail_q;
  assign finish = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_priv_key_gen.sv
// +----------------------------------------------------------------------------+
// | tb_priv_key_gen                                                            |
// | Directed and random checks of priv_key_gen against an arithmetic model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_priv_key_gen;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   e;
  logic [2*W-1:0] phi;
  logic [2*W-1:0] d;
  logic           fail;
  logic           finish;

  priv_key_gen #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .e      (e),
    .phi    (phi),
    .d      (d),
    .fail   (fail),
    .finish (finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectations published by the stimulus, consumed by the compare process.
  bit             exp_active = 1'b0;
  int             exp_c0 = 0;
  int             exp_fin_cyc = 0;
  logic [2*W-1:0] exp_d = '0;
  logic           exp_fail = 1'b0;
  longint         exp_e = 0;
  longint         exp_phi = 0;
  int             lit_d = -1;
  int             lit_fail = -1;
  int             lit_lat = -1;
  bit             chk_zero = 1'b0;

  int vec = 0;
  int mis = 0;
  bit cmp_fin;

  initial begin
    forever begin
      @(negedge clk);
      cmp_fin = exp_active && (cyc == exp_fin_cyc);
      vec++;
      if (finish !== cmp_fin) begin
        mis++;
        $display("FAIL finish @cyc %0d: got %b, want %b", cyc, finish, cmp_fin);
      end
      if (cmp_fin && finish === 1'b1) begin
        vec++;
        if (d !== exp_d) begin
          mis++;
          $display("FAIL d e=%0d phi=%0d: got %0d, want %0d", exp_e, exp_phi, d, exp_d);
        end
        vec++;
        if (fail !== exp_fail) begin
          mis++;
          $display("FAIL fail e=%0d phi=%0d: got %b, want %b", exp_e, exp_phi, fail, exp_fail);
        end
        if (!exp_fail) begin
          vec++;
          if (((exp_e * longint'(d)) % exp_phi) != 1) begin
            mis++;
            $display("FAIL inverse e=%0d phi=%0d: got d=%0d, want e*d mod phi = 1", exp_e, exp_phi, d);
          end
        end
        if (lit_d >= 0) begin
          vec++;
          if (int'(d) != lit_d) begin
            mis++;
            $display("FAIL d_literal: got %0d, want %0d", d, lit_d);
          end
        end
        if (lit_fail >= 0) begin
          vec++;
          if (int'(fail) != lit_fail) begin
            mis++;
            $display("FAIL fail_literal: got %0d, want %0d", fail, lit_fail);
          end
        end
        if (lit_lat >= 0) begin
          vec++;
          if ((cyc - exp_c0) != lit_lat) begin
            mis++;
            $display("FAIL latency: got %0d, want %0d", cyc - exp_c0, lit_lat);
          end
        end
      end
      if (chk_zero) begin
        vec++;
        if (d !== '0 || fail !== 1'b0) begin
          mis++;
          $display("FAIL reset_outputs @cyc %0d: got d=%0d fail=%b, want d=0 fail=0", cyc, d, fail);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int ev, input int pv, input int ld, input int lf, input int ll,
                     input bit poke_mid, input bit poke_fin);
    longint r0, r1, tmp, dm;
    int     k, lat, c0;
    bit     inv, fl;
    inv = (ev == 0) || (pv < 2) || (ev >= pv);
    fl  = inv;
    k   = 0;
    dm  = 0;
    if (!inv) begin
      r0 = pv;
      r1 = ev;
      while (r1 != 0) begin
        tmp = r0 % r1;
        r0  = r1;
        r1  = tmp;
        k++;
      end
      if (r0 != 1) fl = 1'b1;
      else begin
        for (longint x = 1; x < pv; x++) begin
          if ((longint'(ev) * x) % pv == 1) begin
            dm = x;
            break;
          end
        end
      end
    end
    lat = inv ? 3 : 3 + k * (2 * W + 2);
    c0  = cyc;
    exp_e       = ev;
    exp_phi     = pv;
    exp_d       = (2*W)'(dm);
    exp_fail    = fl;
    lit_d       = ld;
    lit_fail    = lf;
    lit_lat     = ll;
    exp_c0      = c0;
    exp_fin_cyc = c0 + lat;
    exp_active  = 1'b1;
    e     = W'(ev);
    phi   = (2*W)'(pv);
    start = 1'b1;
    tick();
    start = 1'b0;
    e     = W'($urandom);
    phi   = (2*W)'($urandom);
    while (cyc <= c0 + lat) begin
      if (poke_mid && cyc == c0 + 10) begin
        start = 1'b1;
        e     = W'($urandom_range(255, 1));
        phi   = (2*W)'($urandom_range(65535, 300));
      end else if (poke_fin && cyc == c0 + lat) begin
        start = 1'b1;
        e     = 8'd5;
        phi   = 16'd96;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (poke_fin) repeat (30) tick();
  endtask

  function automatic longint gcd(input longint a, input longint b);
    longint x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  initial begin
    int c0, ev, pv;
    rst_n    = 1'b0;
    start    = 1'b0;
    e        = '0;
    phi      = '0;
    chk_zero = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk_zero = 1'b0;

    run(7,    120,  103,  0, 39, 1'b0, 1'b0);
    run(17,   3120, 2753, 0, -1, 1'b0, 1'b0);
    run(7,    3120, 1783, 0, -1, 1'b0, 1'b1);
    run(6,    120,  0,    1, 21, 1'b0, 1'b0);
    run(0,    120,  0,    1, 3,  1'b0, 1'b0);
    run(200,  120,  0,    1, 3,  1'b0, 1'b0);
    run(1,    1,    0,    1, 3,  1'b0, 1'b0);
    run(1,    120,  1,    0, 21, 1'b0, 1'b0);

    // Abort in the second iteration; no finish may follow.
    exp_active = 1'b0;
    c0    = cyc;
    e     = 8'd17;
    phi   = 16'd3120;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < c0 + 25) tick();
    rst_n    = 1'b0;
    chk_zero = 1'b1;
    tick();
    rst_n = 1'b1;
    while (cyc < c0 + 95) tick();
    chk_zero = 1'b0;
    run(17, 3120, 2753, 0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ev = 3;
      pv = 300;
      for (int t = 0; t < 100; t++) begin
        pv = $urandom_range(65535, 300);
        ev = $urandom_range(255, 2);
        if (gcd(pv, ev) == 1) break;
      end
      run(ev, pv, -1, -1, -1, (i % 2) == 0, 1'b0);
    end

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
